filter_axis_packer: RTL

FILTER_AXIS_PACKER -- requirements
Module: filter_axis_packer

---
 rtl/filter_axis_pkg.sv | 12 +
 rtl/sync_fifo.sv | 66 ++++++
 rtl/filter_axis_packer.sv | 93 +++++++++
 3 files changed

// File: rtl/filter_axis_pkg.sv
// Shared constants and types for the filter-to-AXI-Stream packer.
package filter_axis_pkg;

  localparam int OUT_W         = 16;
  localparam int SAT_MAX       = 32767;
  localparam int SAT_MIN       = -32768;
  localparam int IN_W_DEFAULT  = 46;
  localparam int SHIFT_DEFAULT = 30;

  typedef logic signed [OUT_W-1:0] sample_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO; dout always shows the head entry.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int LVL_W  = ADDR_W + 1;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              do_push, do_pop;

  assign full    = (level_q == LVL_W'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign dout    = mem[rd_ptr_q];
  // A push while full is legal only because the same-cycle pop frees the slot.
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // NOTE: storage is deliberately not reset; pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/filter_axis_packer.sv
// Rounds and saturates wide filter samples to 16 bits, buffers them and emits
// fixed-length AXI-Stream packets.
module filter_axis_packer
  import filter_axis_pkg::*;
#(
  parameter int IN_W    = IN_W_DEFAULT,
  parameter int SHIFT   = SHIFT_DEFAULT,
  parameter int DEPTH   = 16,
  parameter int PKT_LEN = 256
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [IN_W-1:0]           in_data,
  output logic [OUT_W-1:0]          m_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      m_axis_tlast,
  output logic                      overflow,
  output logic [$clog2(DEPTH):0]    level
);

  localparam int CNT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [CNT_W-1:0]     LAST_BEAT = CNT_W'(PKT_LEN - 1);
  localparam logic signed [IN_W:0] MAX_EXT   = (IN_W + 1)'(SAT_MAX);
  localparam logic signed [IN_W:0] MIN_EXT   = (IN_W + 1)'(SAT_MIN);

  logic signed [IN_W:0] in_ext, shifted, rounded;
  sample_t              conv;
  logic                 sat_valid_q, sat_valid_d;
  sample_t              sat_data_q, sat_data_d;
  logic [CNT_W-1:0]     beat_q, beat_d;
  logic                 overflow_q, overflow_d;
  logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [OUT_W-1:0]     fifo_dout;

  // One guard bit keeps the rounding add from wrapping before saturation.
  always_comb begin
    in_ext  = {in_data[IN_W-1], in_data};
    shifted = in_ext >>> SHIFT;
    rounded = shifted + $signed({{IN_W{1'b0}}, in_data[SHIFT-1]});
    if (rounded > MAX_EXT)      conv = sample_t'(SAT_MAX);
    else if (rounded < MIN_EXT) conv = sample_t'(SAT_MIN);
    else                        conv = rounded[OUT_W-1:0];
  end

  assign fifo_pop  = ~fifo_empty & m_axis_tready;
  assign fifo_push = sat_valid_q & (~fifo_full | fifo_pop);

  always_comb begin
    sat_valid_d = in_valid;
    sat_data_d  = in_valid ? conv : sat_data_q;
    beat_d      = beat_q;
    if (fifo_pop) beat_d = (beat_q == LAST_BEAT) ? '0 : beat_q + CNT_W'(1);
    overflow_d  = overflow_q | (sat_valid_q & fifo_full & ~fifo_pop);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sat_valid_q <= 1'b0;
      sat_data_q  <= '0;
      beat_q      <= '0;
      overflow_q  <= 1'b0;
    end else begin
      sat_valid_q <= sat_valid_d;
      sat_data_q  <= sat_data_d;
      beat_q      <= beat_d;
      overflow_q  <= overflow_d;
    end
  end

  sync_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (sat_data_q),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  // Masking with empty keeps tdata at zero after reset regardless of storage contents.
  assign m_axis_tdata  = fifo_empty ? '0 : fifo_dout;
  assign m_axis_tvalid = ~fifo_empty;
  assign m_axis_tlast  = ~fifo_empty & (beat_q == LAST_BEAT);
  assign overflow      = overflow_q;

endmodule
